// File: rtl/pkt_meta_gen_if.sv
// Bus bundle for pkt_meta_gen: ingress flit stream, packet-buffer flit stream,
// metadata record stream, buffer occupancy feedback and statistics counters.
// The slave modport is the generator's view; master is the surrounding logic.
interface pkt_meta_gen_if #(
  parameter int DWIDTH      = 512,
  parameter int QID_WIDTH   = 13,
  parameter int SIZE_WIDTH  = 16,
  parameter int OCCUP_WIDTH = 10
);
  logic [DWIDTH-1:0]      in_data;
  logic                   in_sop;
  logic                   in_eop;
  logic [QID_WIDTH-1:0]   in_pkt_qid;
  logic [QID_WIDTH-1:0]   in_dsc_qid;
  logic                   in_valid;
  logic                   in_ready;

  logic [DWIDTH-1:0]      pkt_data;
  logic                   pkt_sop;
  logic                   pkt_eop;
  logic                   pkt_valid;
  logic                   pkt_ready;
  logic [OCCUP_WIDTH-1:0] pkt_buf_occup;

  logic [QID_WIDTH-1:0]   meta_dsc_qid;
  logic [QID_WIDTH-1:0]   meta_pkt_qid;
  logic [SIZE_WIDTH-1:0]  meta_size;
  logic                   meta_valid;
  logic                   meta_ready;
  logic [OCCUP_WIDTH-1:0] meta_buf_occup;

  logic                   sw_reset;
  logic [31:0]            drop_cnt;
  logic [31:0]            err_cnt;

  modport master (
    output in_data, in_sop, in_eop, in_pkt_qid, in_dsc_qid, in_valid,
    input  in_ready,
    input  pkt_data, pkt_sop, pkt_eop, pkt_valid,
    output pkt_ready, pkt_buf_occup,
    input  meta_dsc_qid, meta_pkt_qid, meta_size, meta_valid,
    output meta_ready, meta_buf_occup,
    output sw_reset,
    input  drop_cnt, err_cnt
  );

  modport slave (
    input  in_data, in_sop, in_eop, in_pkt_qid, in_dsc_qid, in_valid,
    output in_ready,
    output pkt_data, pkt_sop, pkt_eop, pkt_valid,
    input  pkt_ready, pkt_buf_occup,
    output meta_dsc_qid, meta_pkt_qid, meta_size, meta_valid,
    input  meta_ready, meta_buf_occup,
    input  sw_reset,
    output drop_cnt, err_cnt
  );
endinterface

// File: rtl/pkt_meta_gen.sv
// Ingress stage in front of the FPGA-to-CPU packet and metadata buffers.
// Forwards admitted packets flit by flit through a one-stage output register
// and emits one {dsc_qid, pkt_qid, size} record per packet at its end.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | between packets; next flit should be a SOP
//   FWD   | forwarding an admitted packet, size_q flits sent so far
//   DROP  | discarding the rest of a rejected or oversize packet
module pkt_meta_gen #(
  parameter int DWIDTH         = 512,
  parameter int QID_WIDTH      = 13,
  parameter int SIZE_WIDTH     = 16,
  parameter int MAX_PKT_FLITS  = 24,
  parameter int PKT_BUF_DEPTH  = 512,
  parameter int META_BUF_DEPTH = 512,
  parameter int SLACK          = 4
) (
  input logic          clk,
  input logic          rst,
  pkt_meta_gen_if.slave bus
);
  localparam int OCCUP_WIDTH = $clog2(PKT_BUF_DEPTH) + 1;
  localparam int SUM_WIDTH   = OCCUP_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t                state_q, state_d, state_n;
  logic [SIZE_WIDTH-1:0] size_q, size_d, size_n, size_inc;
  logic [QID_WIDTH-1:0]  pqid_q, pqid_d, pqid_n;
  logic [QID_WIDTH-1:0]  dqid_q, dqid_d, dqid_n;
  logic                  orphan_q, orphan_d, orphan_n;

  logic [DWIDTH-1:0]     pkt_data_q, pkt_data_d;
  logic                  pkt_sop_q, pkt_sop_d;
  logic                  pkt_eop_q, pkt_eop_d;
  logic                  pkt_valid_q, pkt_valid_d;

  logic [QID_WIDTH-1:0]  meta_dqid_q, meta_dqid_d;
  logic [QID_WIDTH-1:0]  meta_pqid_q, meta_pqid_d;
  logic [SIZE_WIDTH-1:0] meta_size_q, meta_size_d;
  logic                  meta_valid_q, meta_valid_d;

  logic [31:0]           drop_cnt_q, drop_cnt_d;
  logic [31:0]           err_cnt_q, err_cnt_d;

  logic [SUM_WIDTH-1:0]  pkt_sum, meta_sum;
  logic                  admit, out_free, in_ready, accept;
  logic                  take_sop, fwd, force_eop, emit, drop_inc, err_inc;
  logic [SIZE_WIDTH-1:0] emit_size;
  logic [QID_WIDTH-1:0]  emit_pqid, emit_dqid;

  assign pkt_sum  = {1'b0, bus.pkt_buf_occup}  + SUM_WIDTH'(MAX_PKT_FLITS + SLACK);
  assign meta_sum = {1'b0, bus.meta_buf_occup} + SUM_WIDTH'(1 + SLACK);
  assign admit    = (pkt_sum <= SUM_WIDTH'(PKT_BUF_DEPTH)) &&
                    (meta_sum <= SUM_WIDTH'(META_BUF_DEPTH));
  assign size_inc = size_q + SIZE_WIDTH'(1);

  // Per-flit decision, evaluated as if the presented flit were accepted
  always_comb begin
    state_n   = state_q;
    size_n    = size_q;
    pqid_n    = pqid_q;
    dqid_n    = dqid_q;
    orphan_n  = orphan_q;
    take_sop  = 1'b0;
    fwd       = 1'b0;
    force_eop = 1'b0;
    emit      = 1'b0;
    emit_size = size_q;
    emit_pqid = pqid_q;
    emit_dqid = dqid_q;
    drop_inc  = 1'b0;
    err_inc   = 1'b0;
    case (state_q)
      FWD: begin
        if (bus.in_sop) begin
          // missing EOP: close the truncated packet, then admit the new one
          emit     = 1'b1;
          err_inc  = 1'b1;
          take_sop = 1'b1;
        end else begin
          fwd    = 1'b1;
          size_n = size_inc;
          if (bus.in_eop) begin
            emit      = 1'b1;
            emit_size = size_inc;
            state_n   = IDLE;
          end else if (size_inc == SIZE_WIDTH'(MAX_PKT_FLITS)) begin
            force_eop = 1'b1;
            emit      = 1'b1;
            emit_size = size_inc;
            err_inc   = 1'b1;
            state_n   = DROP;
          end
        end
      end
      DROP: begin
        if (bus.in_sop) begin
          take_sop = 1'b1;
        end else if (bus.in_eop) begin
          state_n = IDLE;
        end
      end
      default: begin
        if (bus.in_sop) begin
          take_sop = 1'b1;
        end else begin
          err_inc  = !orphan_q;
          orphan_n = 1'b1;
        end
      end
    endcase
    if (take_sop) begin
      orphan_n = 1'b0;
      if (admit && bus.in_eop) begin
        if (emit) begin
          // meta slot already taken by the truncated packet this cycle
          drop_inc = 1'b1;
        end else begin
          fwd       = 1'b1;
          emit      = 1'b1;
          emit_size = SIZE_WIDTH'(1);
          emit_pqid = bus.in_pkt_qid;
          emit_dqid = bus.in_dsc_qid;
        end
        state_n = IDLE;
      end else if (admit) begin
        fwd     = 1'b1;
        size_n  = SIZE_WIDTH'(1);
        pqid_n  = bus.in_pkt_qid;
        dqid_n  = bus.in_dsc_qid;
        state_n = FWD;
      end else begin
        drop_inc = 1'b1;
        state_n  = bus.in_eop ? IDLE : DROP;
      end
    end
  end

  assign out_free = !pkt_valid_q || bus.pkt_ready;
  assign in_ready = !rst && out_free && !(emit && meta_valid_q && !bus.meta_ready);
  assign accept   = bus.in_valid && in_ready;

  // Commit decisions on accept; output registers and saturating counters
  always_comb begin
    state_d  = accept ? state_n  : state_q;
    size_d   = accept ? size_n   : size_q;
    pqid_d   = accept ? pqid_n   : pqid_q;
    dqid_d   = accept ? dqid_n   : dqid_q;
    orphan_d = accept ? orphan_n : orphan_q;

    pkt_valid_d = pkt_valid_q;
    pkt_data_d  = pkt_data_q;
    pkt_sop_d   = pkt_sop_q;
    pkt_eop_d   = pkt_eop_q;
    if (out_free) begin
      pkt_valid_d = accept && fwd;
      if (accept && fwd) begin
        pkt_data_d = bus.in_data;
        pkt_sop_d  = bus.in_sop;
        pkt_eop_d  = bus.in_eop || force_eop;
      end
    end

    meta_valid_d = meta_valid_q && !bus.meta_ready;
    meta_dqid_d  = meta_dqid_q;
    meta_pqid_d  = meta_pqid_q;
    meta_size_d  = meta_size_q;
    if (accept && emit) begin
      meta_valid_d = 1'b1;
      meta_dqid_d  = emit_dqid;
      meta_pqid_d  = emit_pqid;
      meta_size_d  = emit_size;
    end

    drop_cnt_d = drop_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (bus.sw_reset) begin
      drop_cnt_d = '0;
      err_cnt_d  = '0;
    end else begin
      if (accept && drop_inc && drop_cnt_q != 32'hFFFF_FFFF) drop_cnt_d = drop_cnt_q + 32'd1;
      if (accept && err_inc && err_cnt_q != 32'hFFFF_FFFF)   err_cnt_d  = err_cnt_q + 32'd1;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      size_q       <= '0;
      pqid_q       <= '0;
      dqid_q       <= '0;
      orphan_q     <= 1'b0;
      pkt_valid_q  <= 1'b0;
      pkt_data_q   <= '0;
      pkt_sop_q    <= 1'b0;
      pkt_eop_q    <= 1'b0;
      meta_valid_q <= 1'b0;
      meta_dqid_q  <= '0;
      meta_pqid_q  <= '0;
      meta_size_q  <= '0;
      drop_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      pqid_q       <= pqid_d;
      dqid_q       <= dqid_d;
      orphan_q     <= orphan_d;
      pkt_valid_q  <= pkt_valid_d;
      pkt_data_q   <= pkt_data_d;
      pkt_sop_q    <= pkt_sop_d;
      pkt_eop_q    <= pkt_eop_d;
      meta_valid_q <= meta_valid_d;
      meta_dqid_q  <= meta_dqid_d;
      meta_pqid_q  <= meta_pqid_d;
      meta_size_q  <= meta_size_d;
      drop_cnt_q   <= drop_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.pkt_data     = pkt_data_q;
  assign bus.pkt_sop      = pkt_sop_q;
  assign bus.pkt_eop      = pkt_eop_q;
  assign bus.pkt_valid    = pkt_valid_q;
  assign bus.meta_dsc_qid = meta_dqid_q;
  assign bus.meta_pkt_qid = meta_pqid_q;
  assign bus.meta_size    = meta_size_q;
  assign bus.meta_valid   = meta_valid_q;
  assign bus.drop_cnt     = drop_cnt_q;
  assign bus.err_cnt      = err_cnt_q;
endmodule

// File: tb/tb_pkt_meta_gen.sv
// Directed bench for pkt_meta_gen: expected flits and meta records are queued
// by the stimulus and compared in order by negedge monitors.
module tb_pkt_meta_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pkt_meta_gen_if bus ();

  pkt_meta_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad = 0;
  int meta_seen = 0;
  bit tog_en = 1'b0;

  logic [33:0] exp_flit_q[$];   // {sop, eop, id}
  logic [41:0] exp_meta_q[$];   // {dsc_qid, pkt_qid, size}
  logic [33:0] fe;
  logic [41:0] me;

  task automatic check_eq(input string tag, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // packet-buffer ready: steady 1, or alternating while tog_en is set
  always @(posedge clk) begin
    #1;
    bus.pkt_ready = tog_en ? ~bus.pkt_ready : 1'b1;
  end

  always @(negedge clk) begin
    if (bus.pkt_valid === 1'b1 && bus.pkt_ready === 1'b1) begin
      check_eq("pkt_pending", 96'(exp_flit_q.size() != 0), 96'(1));
      if (exp_flit_q.size() != 0) begin
        fe = exp_flit_q.pop_front();
        check_eq("pkt_flit", {bus.pkt_sop, bus.pkt_eop, bus.pkt_data[31:0]}, fe);
        check_eq("pkt_data_hi", bus.pkt_data[511:480], fe[31:0]);
      end
    end
    if (bus.meta_valid === 1'b1 && bus.meta_ready === 1'b1) begin
      meta_seen++;
      check_eq("meta_pending", 96'(exp_meta_q.size() != 0), 96'(1));
      if (exp_meta_q.size() != 0) begin
        me = exp_meta_q.pop_front();
        check_eq("meta_rec", {bus.meta_dsc_qid, bus.meta_pkt_qid, bus.meta_size}, me);
      end
    end
  end

  // call just after a posedge; returns just after the accepting posedge
  task automatic send_flit(input logic [31:0] id, input logic sop, input logic eop,
                           input logic [12:0] pq, input logic [12:0] dq);
    int n;
    n = 0;
    bus.in_data    = {16{id}};
    bus.in_sop     = sop;
    bus.in_eop     = eop;
    bus.in_pkt_qid = pq;
    bus.in_dsc_qid = dq;
    bus.in_valid   = 1'b1;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check_eq("in_ready_timeout", 96'(n), 96'(0));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  // n_exp: flits expected on pkt_* (0 = dropped); the last expected one carries eop
  task automatic send_pkt(input int k, input int len, input logic [12:0] pq,
                          input logic [12:0] dq, input int n_exp);
    for (int j = 1; j <= len; j++)
      if (j <= n_exp) exp_flit_q.push_back({j == 1, j == n_exp, 16'(k), 16'(j)});
    if (n_exp > 0) exp_meta_q.push_back({dq, pq, 16'(n_exp)});
    for (int j = 1; j <= len; j++)
      send_flit({16'(k), 16'(j)}, j == 1, j == len, pq, dq);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_flit_q.size() != 0 || exp_meta_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("flit_q_drain", 96'(exp_flit_q.size()), 96'(0));
    check_eq("meta_q_drain", 96'(exp_meta_q.size()), 96'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_data = '0;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
    bus.in_pkt_qid = '0;
    bus.in_dsc_qid = '0;
    bus.in_valid = 1'b0;
    bus.pkt_buf_occup = '0;
    bus.meta_buf_occup = '0;
    bus.meta_ready = 1'b1;
    bus.sw_reset = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_pkt_valid", bus.pkt_valid, 0);
    check_eq("rst_meta_valid", bus.meta_valid, 0);
    check_eq("rst_drop_cnt", bus.drop_cnt, 0);
    check_eq("rst_err_cnt", bus.err_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // 3-flit packet, qids 5/2; first flit visible one cycle after accept
    exp_flit_q.push_back({1'b1, 1'b0, 32'h0001_0001});
    exp_flit_q.push_back({1'b0, 1'b0, 32'h0001_0002});
    exp_flit_q.push_back({1'b0, 1'b1, 32'h0001_0003});
    exp_meta_q.push_back({13'd2, 13'd5, 16'd3});
    send_flit(32'h0001_0001, 1'b1, 1'b0, 13'd5, 13'd2);
    check_eq("lat_pkt_valid", bus.pkt_valid, 1);
    check_eq("lat_pkt_sop", bus.pkt_sop, 1);
    send_flit(32'h0001_0002, 1'b0, 1'b0, 13'd5, 13'd2);
    send_flit(32'h0001_0003, 1'b0, 1'b1, 13'd5, 13'd2);
    wait_drain();

    // admission boundaries: 485 rejects, 484 admits; meta occupancy 508 rejects, 507 admits
    bus.pkt_buf_occup = 10'd485;
    send_pkt(2, 2, 13'd1, 13'd1, 0);
    check_eq("adm_drop_cnt1", bus.drop_cnt, 1);
    bus.pkt_buf_occup = 10'd484;
    send_pkt(3, 1, 13'd1, 13'd1, 1);
    bus.pkt_buf_occup = 10'd0;
    bus.meta_buf_occup = 10'd508;
    send_pkt(4, 1, 13'd2, 13'd2, 0);
    check_eq("adm_drop_cnt2", bus.drop_cnt, 2);
    bus.meta_buf_occup = 10'd507;
    send_pkt(5, 1, 13'd3, 13'd3, 1);
    bus.meta_buf_occup = 10'd0;
    wait_drain();
    check_eq("adm_err_cnt", bus.err_cnt, 0);

    // meta backpressure: second single-flit EOP stalls until meta_ready
    exp_flit_q.push_back({1'b1, 1'b1, 32'h001E_0001});
    exp_meta_q.push_back({13'd3, 13'd7, 16'd1});
    exp_flit_q.push_back({1'b1, 1'b1, 32'h001F_0001});
    exp_meta_q.push_back({13'd2, 13'd8, 16'd1});
    bus.meta_ready = 1'b0;
    send_flit(32'h001E_0001, 1'b1, 1'b1, 13'd7, 13'd3);
    bus.in_data = {16{32'h001F_0001}};
    bus.in_sop = 1'b1;
    bus.in_eop = 1'b1;
    bus.in_pkt_qid = 13'd8;
    bus.in_dsc_qid = 13'd2;
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("stall_in_ready", bus.in_ready, 0);
    check_eq("stall_meta_valid", bus.meta_valid, 1);
    check_eq("stall_meta_rec", {bus.meta_dsc_qid, bus.meta_pkt_qid, bus.meta_size},
             {13'd3, 13'd7, 16'd1});
    @(posedge clk);
    #1;
    bus.meta_ready = 1'b1;
    @(negedge clk);
    check_eq("unstall_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
    wait_drain();

    // oversize: 30 flits -> 24 forwarded, 24th forced eop, meta size 24
    send_pkt(6, 30, 13'd9, 13'd4, 24);
    wait_drain();
    check_eq("ovs_err_cnt", bus.err_cnt, 1);
    check_eq("ovs_drop_cnt", bus.drop_cnt, 2);

    // orphan burst of two flits counts one error
    send_flit(32'h0007_0001, 1'b0, 1'b0, 13'd0, 13'd0);
    send_flit(32'h0007_0002, 1'b0, 1'b1, 13'd0, 13'd0);
    check_eq("orphan_err_cnt", bus.err_cnt, 2);

    // missing EOP: SOP in FWD closes the 2-flit packet and starts a new one
    exp_flit_q.push_back({1'b1, 1'b0, 32'h0008_0001});
    exp_flit_q.push_back({1'b0, 1'b0, 32'h0008_0002});
    exp_meta_q.push_back({13'd3, 13'd3, 16'd2});
    send_flit(32'h0008_0001, 1'b1, 1'b0, 13'd3, 13'd3);
    send_flit(32'h0008_0002, 1'b0, 1'b0, 13'd3, 13'd3);
    send_pkt(9, 2, 13'd4, 13'd4, 2);
    wait_drain();
    check_eq("trunc_err_cnt", bus.err_cnt, 3);

    // reset mid-packet: no meta for the aborted packet, next packet normal
    exp_flit_q.push_back({1'b1, 1'b0, 32'h0028_0001});
    send_flit(32'h0028_0001, 1'b1, 1'b0, 13'd11, 13'd6);
    rst = 1'b1;
    bus.in_data = {16{32'h0028_0002}};
    bus.in_valid = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("mid_rst_pkt_valid", bus.pkt_valid, 0);
    check_eq("mid_rst_meta_valid", bus.meta_valid, 0);
    check_eq("mid_rst_err_cnt", bus.err_cnt, 0);
    send_pkt(41, 2, 13'd12, 13'd1, 2);
    wait_drain();

    // pkt_ready alternating; every 4th packet rejected on occupancy
    begin
      int m0;
      m0 = meta_seen;
      tog_en = 1'b1;
      for (int k = 0; k < 20; k++) begin
        bus.pkt_buf_occup = (k % 4 == 3) ? 10'd500 : 10'd0;
        send_pkt(100 + k, (k % 5) + 1, 13'(k), 13'(k + 1), (k % 4 == 3) ? 0 : (k % 5) + 1);
      end
      bus.pkt_buf_occup = 10'd0;
      wait_drain();
      tog_en = 1'b0;
      check_eq("tog_meta_count", 96'(meta_seen - m0), 96'(15));
      check_eq("tog_drop_cnt", bus.drop_cnt, 5);
    end

    // sw_reset clears counters
    bus.sw_reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("swr_drop_cnt", bus.drop_cnt, 0);
    bus.sw_reset = 1'b0;

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
